// File: rtl/multicycle_controller.sv
// Control FSM for a multi-cycle MIPS datapath with one shared memory and one ALU.
// Ports: clk, reset (sync, active-low), op/funct/zero/mem_ready in; datapath controls out.
// Optional: define MC_ILLEGAL_TRAP_EN to halt on unsupported op/funct and raise illegal.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       lui,
  output logic       ori,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXEC, S_ALUWB, S_BRANCH, S_IMMEX,
    S_IMMWB, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RT    = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state, next;
  state_t bad_next;
  logic [2:0] rfunc;
  logic       funct_ok;

`ifdef MC_ILLEGAL_TRAP_EN
  assign bad_next = S_HALT;
  assign illegal  = reset && (state == S_HALT);
`else
  assign bad_next = S_FETCH;
  assign illegal  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= next;
  end

  // R-type ALU op; the IR is stable, so ALUWB re-decodes the same value.
  always_comb begin
    rfunc    = 3'b000;
    funct_ok = 1'b1;
    case (funct)
      6'b100001: rfunc = 3'b010;
      6'b100011: rfunc = 3'b110;
      6'b100100: rfunc = 3'b000;
      6'b100101: rfunc = 3'b001;
      6'b101011: rfunc = 3'b111;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    lui        = 1'b0;
    ori        = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          next    = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OP_LW, OP_SW:              next = S_MEMADR;
          OP_RT:                     next = S_EXEC;
          OP_BEQ, OP_BNE:            next = S_BRANCH;
          OP_ADDIU, OP_ORI, OP_LUI:  next = S_IMMEX;
          OP_J:                      next = S_JUMP;
          default:                   next = bad_next;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
        next       = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        next     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = rfunc;
        next       = funct_ok ? S_ALUWB : bad_next;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        alucontrol = rfunc;
        next       = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcen       = (op == OP_BNE) ? ~zero : zero;
        next       = S_FETCH;
      end
      S_IMMEX, S_IMMWB: begin
        if (op == OP_LUI) begin
          lui = 1'b1;
        end else begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          ori        = (op == OP_ORI);
          alucontrol = (op == OP_ORI) ? 3'b001 : 3'b010;
        end
        regwrite = (state == S_IMMWB);
        next     = (state == S_IMMEX) ? S_IMMWB : S_FETCH;
      end
      S_JUMP: begin
        pcen  = 1'b1;
        pcsrc = 2'b10;
        next  = S_FETCH;
      end
      S_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
        next = S_HALT;
`else
        next = S_FETCH;
`endif
      end
      default: next = S_FETCH;
    endcase
    if (!reset) begin
      next       = S_FETCH;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b000;
      regwrite   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      lui        = 1'b0;
      ori        = 1'b0;
    end
  end

endmodule
